// File: rtl/carrier_lock_ctrl_pkg.sv
// Shared definitions for the carrier lock controller: data width, state
// encodings, default lock thresholds and the saturating magnitude helper.
package carrier_lock_ctrl_pkg;

  localparam int DATA_W = 26;

  localparam logic [33:0] LOCK_TH_DEF   = 34'd2097152;
  localparam logic [33:0] UNLOCK_TH_DEF = 34'd8388608;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_CHECK = 2'd1,
    ST_TRACK = 2'd2
  } lock_state_e;

  // The most negative input has no positive twin; clamp it to the largest magnitude.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1])
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

endpackage

// File: rtl/carrier_lock_ctrl_window_meter.sv
// Windowed |pd| energy meter: accumulates magnitudes over 2^WIN_LOG2 samples
// and flags the finished window as good (below LOCK_TH) or bad (above UNLOCK_TH).
module lock_window_meter
  import carrier_lock_ctrl_pkg::*;
#(
  parameter int                          WIN_LOG2  = 8,
  parameter logic [DATA_W+WIN_LOG2-1:0]  LOCK_TH   = LOCK_TH_DEF,
  parameter logic [DATA_W+WIN_LOG2-1:0]  UNLOCK_TH = UNLOCK_TH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     win_end_o,
  output logic                     good_o,
  output logic                     bad_o
);

  localparam int ACC_W = DATA_W + WIN_LOG2;

  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   mag;

  // The window-end sample is folded into the sum that gets judged.
  assign mag       = abs_sat(sample_i);
  assign sum       = acc_q + ACC_W'(mag);
  assign win_end_o = en_i && (win_cnt_q == '1);
  assign good_o    = (sum < LOCK_TH);
  assign bad_o     = (sum > UNLOCK_TH);

  always_comb begin
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    if (clr_i) begin
      win_cnt_d = '0;
      acc_d     = '0;
    end else if (en_i) begin
      win_cnt_d = win_cnt_q + 1'b1;
      acc_d     = win_end_o ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/carrier_lock_ctrl.sv
// Carrier lock controller: sequences ACQ -> CHECK -> TRACK, picks the phase
// detector feeding the loop filter and reports lock / loss of lock.
module carrier_lock_ctrl
  import carrier_lock_ctrl_pkg::*;
#(
  parameter int                          ACQ_MIN   = 16000,
  parameter int                          WIN_LOG2  = 8,
  parameter logic [DATA_W+WIN_LOG2-1:0]  LOCK_TH   = LOCK_TH_DEF,
  parameter logic [DATA_W+WIN_LOG2-1:0]  UNLOCK_TH = UNLOCK_TH_DEF,
  parameter int                          LOCK_CNT  = 4,
  parameter int                          LOSS_CNT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic signed [DATA_W-1:0] pd_polar,
  input  logic signed [DATA_W-1:0] pd_dd,
  output logic signed [DATA_W-1:0] pd,
  output logic                     mode,
  output logic                     locked,
  output logic                     lock_lost,
  output logic [1:0]               state
);

  localparam int ACQ_W  = $clog2(ACQ_MIN + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  lock_state_e               state_q, state_d;
  logic [ACQ_W-1:0]          acq_q, acq_d;
  logic [GOOD_W-1:0]         good_q, good_d;
  logic [BAD_W-1:0]          bad_q, bad_d;
  logic signed [DATA_W-1:0]  pd_q;
  logic                      mode_q, locked_q, lost_q, lost_d;

  logic                      meter_en, meter_clr, win_end, win_good, win_bad;
  logic signed [DATA_W-1:0]  meter_sample;

  assign meter_sample = (state_q == ST_TRACK) ? pd_dd : pd_polar;
  assign meter_en     = (state_q == ST_CHECK) || (state_q == ST_TRACK);
  assign meter_clr    = (state_d != state_q) || (state_q == ST_ACQ);

  lock_window_meter #(
    .WIN_LOG2  (WIN_LOG2),
    .LOCK_TH   (LOCK_TH),
    .UNLOCK_TH (UNLOCK_TH)
  ) u_meter (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (meter_clr),
    .en_i      (meter_en),
    .sample_i  (meter_sample),
    .win_end_o (win_end),
    .good_o    (win_good),
    .bad_o     (win_bad)
  );

  always_comb begin
    state_d = state_q;
    acq_d   = '0;
    good_d  = good_q;
    bad_d   = bad_q;
    lost_d  = 1'b0;
    case (state_q)
      ST_ACQ: begin
        if (acq_q == ACQ_W'(ACQ_MIN - 1)) state_d = ST_CHECK;
        else                              acq_d   = acq_q + 1'b1;
      end
      ST_CHECK: begin
        if (win_end) begin
          if (!win_good)                              good_d  = '0;
          else if (good_q == GOOD_W'(LOCK_CNT - 1))   state_d = ST_TRACK;
          else                                        good_d  = good_q + 1'b1;
        end
      end
      ST_TRACK: begin
        if (win_end) begin
          if (!win_bad)                               bad_d = '0;
          else if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
            state_d = ST_ACQ;
            lost_d  = 1'b1;
          end else                                    bad_d = bad_q + 1'b1;
        end
      end
      default: state_d = ST_ACQ;
    endcase
    // A restart overrides any window decision made in the same cycle.
    if (restart) begin
      state_d = ST_ACQ;
      acq_d   = '0;
      lost_d  = 1'b0;
    end
    if (state_d != state_q) begin
      acq_d  = '0;
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACQ;
      acq_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      pd_q     <= '0;
      mode_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acq_q    <= acq_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      pd_q     <= (state_q == ST_TRACK) ? pd_dd : pd_polar;
      mode_q   <= (state_d == ST_TRACK);
      locked_q <= (state_d == ST_TRACK);
      lost_q   <= lost_d;
    end
  end

  assign pd        = pd_q;
  assign mode      = mode_q;
  assign locked    = locked_q;
  assign lock_lost = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
// Directed bench for carrier_lock_ctrl: acquisition timing, lock, loss,
// window threshold boundaries, restart priority and asynchronous reset.
`timescale 1ns/100ps
module tb_carrier_lock_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               restart;
  logic signed [25:0] pd_polar;
  logic signed [25:0] pd_dd;
  logic signed [25:0] pd;
  logic               mode;
  logic               locked;
  logic               lock_lost;
  logic [1:0]         state;

  int checks = 0;
  int errors = 0;

  carrier_lock_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .pd_polar  (pd_polar),
    .pd_dd     (pd_dd),
    .pd        (pd),
    .mode      (mode),
    .locked    (locked),
    .lock_lost (lock_lost),
    .state     (state)
  );

  always #62.5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
  endtask

  initial begin
    // Reset: outputs must be cleared without waiting for a clock edge.
    rst      = 1'b1;
    restart  = 1'b0;
    pd_polar = 26'sd123;
    pd_dd    = -26'sd5;
    #1;
    chk("rst_state", state, 0);
    chk("rst_pd", pd, 0);
    chk("rst_mode", mode, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_lost", lock_lost, 0);
    tick_n(3);
    chk("rst_hold_state", state, 0);
    chk("rst_hold_pd", pd, 0);

    rst = 1'b0;
    tick();
    chk("acq_pd_polar", pd, 123);
    chk("acq_state", state, 0);
    chk("acq_mode", mode, 0);

    // Acquisition lasts exactly 16000 cycles, then four clean windows lock.
    pd_polar = 26'sd0;
    pd_dd    = 26'sd0;
    tick_n(15998);
    chk("acq_before_end", state, 0);
    tick();
    chk("check_entry", state, 1);
    chk("check_mode", mode, 0);
    chk("check_locked", locked, 0);
    tick_n(1023);
    chk("check_before_lock", state, 1);
    tick();
    chk("track_entry", state, 2);
    chk("track_mode", mode, 1);
    chk("track_locked", locked, 1);
    chk("track_no_lost", lock_lost, 0);

    // TRACK: pd follows pd_dd; large constant error forces loss after 4 windows.
    pd_dd = 26'sd777;
    tick();
    chk("track_pd_dd", pd, 777);
    pd_dd    = 26'sd40000;
    pd_polar = 26'sd555;
    tick_n(1022);
    chk("track_before_loss", state, 2);
    chk("track_before_loss_lost", lock_lost, 0);
    tick();
    chk("loss_state", state, 0);
    chk("loss_pulse", lock_lost, 1);
    chk("loss_locked", locked, 0);
    chk("loss_mode", mode, 0);
    chk("loss_pd_last_dd", pd, 40000);
    tick();
    chk("loss_pulse_end", lock_lost, 0);
    chk("loss_pd_polar", pd, 555);

    // Back through ACQ; window sum 8191*256 is good, 8192*256 (= LOCK_TH) is not.
    pd_polar = 26'sd8191;
    tick_n(15998);
    chk("reacq_before_end", state, 0);
    tick();
    chk("reacq_check_entry", state, 1);
    for (int w = 0; w < 8; w++) begin
      pd_polar = (w % 4 == 3) ? 26'sd8192 : 26'sd8191;
      tick_n(256);
      chk($sformatf("alt_window_%0d", w), state, 1);
    end

    // Restart on the window end that would have locked wins over TRACK.
    pd_polar = 26'sd8191;
    tick_n(768);
    chk("pre_restart_check", state, 1);
    tick_n(255);
    restart = 1'b1;
    tick();
    chk("restart_state", state, 0);
    chk("restart_no_lost", lock_lost, 0);
    chk("restart_locked", locked, 0);
    chk("restart_mode", mode, 0);
    tick_n(5);
    chk("restart_hold", state, 0);
    restart  = 1'b0;
    pd_polar = 26'sd0;
    tick_n(15999);
    chk("restart_acq_before_end", state, 0);
    tick();
    chk("restart_check_entry", state, 1);
    tick_n(1024);
    chk("second_track_entry", state, 2);

    // Most negative pd_dd: magnitude saturates, window is bad, no wrap to good.
    pd_dd = -26'sd33554432;
    tick();
    chk("sat_pd_raw", pd, -33554432);
    tick_n(1022);
    chk("sat_before_loss", state, 2);
    tick();
    chk("sat_loss_state", state, 0);
    chk("sat_loss_pulse", lock_lost, 1);

    // Reach TRACK again, then hit reset mid-window.
    pd_dd = 26'sd0;
    tick_n(15999);
    chk("third_acq_before_end", state, 0);
    tick();
    chk("third_check_entry", state, 1);
    tick_n(1024);
    chk("third_track_entry", state, 2);
    pd_dd = 26'sd100;
    tick_n(100);
    chk("mid_window_pd", pd, 100);
    rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_pd", pd, 0);
    chk("async_rst_mode", mode, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_lost", lock_lost, 0);
    tick_n(2);
    rst      = 1'b0;
    pd_polar = -26'sd9;
    tick();
    chk("post_rst_pd", pd, -9);
    chk("post_rst_state", state, 0);
    tick_n(15998);
    chk("post_rst_acq_before_end", state, 0);
    tick();
    chk("post_rst_check_entry", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carrier_lock_ctrl.md
CARRIER_LOCK_CTRL -- requirements
Module: carrier_lock_ctrl

Interface
REQ-001 Parameter ACQ_MIN, default 16000: minimum cycles spent in polarity-detector acquisition.
REQ-002 Parameter WIN_LOG2, default 8: log2 of the lock-measurement window length, so WIN = 256.
REQ-003 Parameter LOCK_TH, default 34'd2097152: window |pd| sum strictly below this counts as a good window.
REQ-004 Parameter UNLOCK_TH, default 34'd8388608: window |pd| sum strictly above this counts as a bad window.
REQ-005 Parameter LOCK_CNT, default 4; parameter LOSS_CNT, default 4: consecutive good or bad windows needed.
REQ-006 Port clk, input, 1: system clock, 8 MHz.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port restart, input, 1: synchronous request to re-enter acquisition.
REQ-009 Port pd_polar, input, signed 26: polarity-decision phase-detector output.
REQ-010 Port pd_dd, input, signed 26: decision-directed phase-detector output.
REQ-011 Port pd, output, signed 26: selected phase error to the loop filter, registered.
REQ-012 Port mode, output, 1: 0 = polarity detector, 1 = DD detector.
REQ-013 Port locked, output, 1: high while in TRACK.
REQ-014 Port lock_lost, output, 1: one-cycle pulse on TRACK->ACQ due to loss.
REQ-015 Port state, output, 2: current state encoding.

Function
REQ-016 States SHALL be ACQ=0, CHECK=1, TRACK=2; encoding 3 unused and SHALL return to ACQ next cycle.
REQ-017 ACQ: SHALL count cycles from 0; when count = ACQ_MIN-1 SHALL enter CHECK next cycle (ACQ lasts exactly ACQ_MIN cycles).
REQ-018 CHECK: SHALL accumulate |pd_polar| over each WIN-cycle window; at window end, good window increments good_cnt, else good_cnt clears; good_cnt reaching LOCK_CNT SHALL enter TRACK next cycle.
REQ-019 CHECK has no timeout; it stays until lock or restart.
REQ-020 TRACK: SHALL accumulate |pd_dd| per window; bad window increments bad_cnt, else bad_cnt clears; bad_cnt reaching LOSS_CNT SHALL enter ACQ and pulse lock_lost.
REQ-021 Selection: pd SHALL register pd_polar in ACQ/CHECK and pd_dd in TRACK, one-cycle latency from the state that owns the cycle.
REQ-022 mode and locked SHALL be registered and change in the same cycle as the state.
REQ-023 |x|: -2^25 SHALL saturate to 2^25-1; accumulator SHALL be unsigned 26+WIN_LOG2 bits, no overflow possible.
REQ-024 Window counter SHALL wrap WIN-1 -> 0; the window-end sample is included in that window's sum.
REQ-025 On every state entry the window counter, accumulator, good_cnt and bad_cnt SHALL clear.
REQ-026 restart high SHALL force ACQ next cycle from any state and SHALL take priority over a simultaneous window-end transition.
REQ-027 restart in TRACK SHALL NOT pulse lock_lost.
REQ-028 restart held high SHALL hold ACQ with its cycle counter at 0.

Reset
REQ-029 rst high SHALL immediately set state=ACQ, pd=0, mode=0, locked=0, lock_lost=0, and clear all counters and accumulators.
REQ-030 rst mid-operation SHALL abort any window; no partial window is evaluated after release.

Structure
REQ-031 Shared package SHALL hold the state encodings, the 26-bit data width and the default thresholds.
REQ-032 One sub-module, lock_window_meter (abs, accumulate, window counter, good/bad compare), SHALL be shared by CHECK and TRACK.

Verification
REQ-033 pd_polar=0 constant -> CHECK entered at cycle 16000; TRACK entered 4*256 = 1024 cycles later; mode=1 and locked=1 in that cycle.
REQ-034 In TRACK, pd_dd=+40000 constant (window sum 10,240,000 > UNLOCK_TH) -> ACQ after 1024 cycles, one lock_lost pulse, pd then follows pd_polar.
REQ-035 In CHECK, pd_polar alternates 3 good and 1 bad window repeatedly -> stays in CHECK indefinitely.
REQ-036 pd_dd=-33554432 in TRACK -> abs saturates to 33554431; bad window declared; no accumulator wrap.
REQ-037 restart asserted on the cycle good_cnt would reach 4 -> ACQ next cycle, not TRACK; lock_lost stays 0.
REQ-038 rst pulsed mid-window in TRACK -> all outputs 0 the same cycle; ACQ restarts counting from 0 after release.
